// File: rtl/bcd_mmss_timer.sv
// MM:SS BCD countdown/count-up timer with preset entry, auto-repeat keys,
// start/pause toggle, clear/abort and a one-clock completion pulse.
module bcd_mmss_timer #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned MAX_MIN    = 99,
  parameter int unsigned HOLD_CYC   = 25000000,
  parameter int unsigned REPEAT_CYC = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        plus,
  input  logic        minus,
  input  logic        start,
  input  logic        clear,
  input  logic        mode,
  output logic        finish,
  output logic        running,
  output logic [15:0] display
);

  localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned REP_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned REP_W   = (REP_MAX > 0) ? $clog2(REP_MAX + 1) : 1;
  localparam logic [3:0]  MAX_T   = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MAX_O   = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  // +1 s on {mt, mo, st, so}; MAX_MIN:59 wraps to 00:00
  function automatic logic [15:0] inc_time(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd9) begin
      r[3:0] = t[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd5) begin
        r[7:4] = t[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (t[15:8] == {MAX_T, MAX_O}) begin
          r[15:8] = 8'h00;
        end else if (t[11:8] != 4'd9) begin
          r[11:8] = t[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = t[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // -1 s on {mt, mo, st, so}; 00:00 wraps to MAX_MIN:59
  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[15:8] == 8'h00) begin
          r[15:8] = {MAX_T, MAX_O};
        end else if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  state_t           state, state_nxt;
  logic [15:0]      preset, preset_nxt;
  logic [15:0]      count, count_nxt;
  logic [PRE_W-1:0] presc, presc_nxt;
  logic [REP_W-1:0] rep_cnt, rep_nxt;
  logic             rep_rpt, rep_rpt_nxt;
  logic             mode_q, mode_nxt;
  logic             finish_nxt;
  logic             plus_q, minus_q, start_q;

  logic             plus_rise, minus_rise, start_rise;
  logic             key_alone, key_rise, tick;
  logic [REP_W-1:0] rep_lim;
  logic [15:0]      stepped, target;

  assign plus_rise  = plus & ~plus_q;
  assign minus_rise = minus & ~minus_q;
  assign start_rise = start & ~start_q;
  assign key_alone  = plus ^ minus;
  assign key_rise   = (plus & ~minus & plus_rise) | (minus & ~plus & minus_rise);
  assign rep_lim    = rep_rpt ? REP_W'(REPEAT_CYC) : REP_W'(HOLD_CYC);
  assign tick       = (presc == PRE_W'(TICK_DIV - 1));
  assign stepped    = mode_q ? inc_time(count) : dec_time(count);
  assign target     = mode_q ? preset : 16'h0000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      preset  <= '0;
      count   <= '0;
      presc   <= '0;
      rep_cnt <= '0;
      rep_rpt <= 1'b0;
      mode_q  <= 1'b0;
      plus_q  <= 1'b0;
      minus_q <= 1'b0;
      start_q <= 1'b0;
      finish  <= 1'b0;
      running <= 1'b0;
      display <= '0;
    end else begin
      state   <= state_nxt;
      preset  <= preset_nxt;
      count   <= count_nxt;
      presc   <= presc_nxt;
      rep_cnt <= rep_nxt;
      rep_rpt <= rep_rpt_nxt;
      mode_q  <= mode_nxt;
      plus_q  <= plus;
      minus_q <= minus;
      start_q <= start;
      finish  <= finish_nxt;
      running <= (state_nxt == RUN);
      display <= (state_nxt == IDLE) ? preset_nxt : count_nxt;
    end
  end

  // Next state, preset editing and run-time counting; clear outranks everything
  always_comb begin
    state_nxt   = state;
    preset_nxt  = preset;
    count_nxt   = count;
    presc_nxt   = presc;
    rep_nxt     = '0;
    rep_rpt_nxt = 1'b0;
    mode_nxt    = mode_q;
    finish_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          preset_nxt = '0;
        end else if (start_rise && (preset != 16'h0000)) begin
          state_nxt = RUN;
          presc_nxt = '0;
          mode_nxt  = mode;
          count_nxt = mode ? 16'h0000 : preset;
        end else if (key_alone) begin
          if (key_rise || (rep_cnt == rep_lim)) begin
            preset_nxt  = plus ? inc_time(preset) : dec_time(preset);
            rep_nxt     = REP_W'(1);
            rep_rpt_nxt = ~key_rise;
          end else begin
            rep_nxt     = rep_cnt + REP_W'(1);
            rep_rpt_nxt = rep_rpt;
          end
        end
      end
      RUN: begin
        if (clear) begin
          state_nxt = IDLE;
        end else if (tick) begin
          presc_nxt = '0;
          count_nxt = stepped;
          if (stepped == target) begin
            state_nxt  = DONE;
            finish_nxt = 1'b1;
          end else if (start_rise) begin
            state_nxt = PAUSE;
          end
        end else begin
          presc_nxt = presc + PRE_W'(1);
          if (start_rise) state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (clear) state_nxt = IDLE;
        else if (start_rise) state_nxt = RUN;
      end
      DONE: begin
        if (clear || start_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd_mmss_timer.sv
// Directed bench for bcd_mmss_timer: expected {finish, running, display}
// words are queued as stimulus is applied and checked as the DUT responds.
module tb_bcd_mmss_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        plus, minus, start, clear, mode;
  logic        finish, running;
  logic [15:0] display;

  typedef struct {
    string       tag;
    logic [17:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;

  bcd_mmss_timer #(
    .TICK_DIV  (2),
    .MAX_MIN   (99),
    .HOLD_CYC  (4),
    .REPEAT_CYC(2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .plus   (plus),
    .minus  (minus),
    .start  (start),
    .clear  (clear),
    .mode   (mode),
    .finish (finish),
    .running(running),
    .display(display)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [15:0] d, input logic r, input logic f);
    exp_t e;
    e.tag = tag;
    e.exp = {f, r, d};
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [17:0] obs;
    obs = {finish, running, display};
    compared++;
    if (sbq.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic [15:0] d, input logic r, input logic f);
    push(tag, d, r, f);
    drain();
  endtask

  task automatic pulse_plus();
    plus = 1'b1; cyc(1); plus = 1'b0; cyc(1);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    plus  = 1'b0;
    minus = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    mode  = 1'b0;
    cyc(3);
    expect_now("reset_state", 16'h0000, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1);
    expect_now("after_reset", 16'h0000, 1'b0, 1'b0);

    // Preset wrap in both directions
    minus = 1'b1; cyc(1); minus = 1'b0;
    expect_now("minus_wrap", 16'h9959, 1'b0, 1'b0);
    cyc(1);
    pulse_plus();
    expect_now("plus_wrap", 16'h0000, 1'b0, 1'b0);
    pulse_plus();
    expect_now("plus_one", 16'h0001, 1'b0, 1'b0);

    // Countdown 00:03
    pulse_plus();
    pulse_plus();
    expect_now("preset_0003", 16'h0003, 1'b0, 1'b0);
    mode = 1'b0;
    pulse_start();
    expect_now("down_start", 16'h0003, 1'b1, 1'b0);
    push("down_e1", 16'h0003, 1'b1, 1'b0);
    push("down_e2", 16'h0002, 1'b1, 1'b0);
    push("down_e3", 16'h0002, 1'b1, 1'b0);
    push("down_e4", 16'h0001, 1'b1, 1'b0);
    push("down_e5", 16'h0001, 1'b1, 1'b0);
    push("down_done", 16'h0000, 1'b0, 1'b1);
    push("down_fin_low", 16'h0000, 1'b0, 1'b0);
    push("down_hold", 16'h0000, 1'b0, 1'b0);
    repeat (8) begin cyc(1); drain(); end
    pulse_start();
    expect_now("done_to_idle", 16'h0003, 1'b0, 1'b0);

    // Countdown across a minute boundary
    do_clear();
    expect_now("clear_idle", 16'h0000, 1'b0, 1'b0);
    repeat (60) pulse_plus();
    expect_now("preset_0100", 16'h0100, 1'b0, 1'b0);
    pulse_start();
    expect_now("borrow_start", 16'h0100, 1'b1, 1'b0);
    push("borrow_e1", 16'h0100, 1'b1, 1'b0);
    push("borrow_e2", 16'h0059, 1'b1, 1'b0);
    push("borrow_e3", 16'h0059, 1'b1, 1'b0);
    push("borrow_e4", 16'h0058, 1'b1, 1'b0);
    repeat (4) begin cyc(1); drain(); end
    do_clear();
    expect_now("borrow_clear", 16'h0100, 1'b0, 1'b0);

    // Count-up to 00:02
    do_clear();
    pulse_plus();
    pulse_plus();
    expect_now("preset_0002", 16'h0002, 1'b0, 1'b0);
    mode = 1'b1;
    pulse_start();
    mode = 1'b0;
    expect_now("up_start", 16'h0000, 1'b1, 1'b0);
    push("up_e1", 16'h0000, 1'b1, 1'b0);
    push("up_e2", 16'h0001, 1'b1, 1'b0);
    push("up_e3", 16'h0001, 1'b1, 1'b0);
    push("up_done", 16'h0002, 1'b0, 1'b1);
    push("up_fin_low", 16'h0002, 1'b0, 1'b0);
    repeat (5) begin cyc(1); drain(); end
    pulse_start();
    expect_now("up_to_idle", 16'h0002, 1'b0, 1'b0);

    // Auto-repeat: steps at edges 0, 4, 6, 8, 10
    do_clear();
    plus = 1'b1;
    push("rep_e0", 16'h0001, 1'b0, 1'b0);
    push("rep_e1", 16'h0001, 1'b0, 1'b0);
    push("rep_e2", 16'h0001, 1'b0, 1'b0);
    push("rep_e3", 16'h0001, 1'b0, 1'b0);
    push("rep_e4", 16'h0002, 1'b0, 1'b0);
    push("rep_e5", 16'h0002, 1'b0, 1'b0);
    push("rep_e6", 16'h0003, 1'b0, 1'b0);
    push("rep_e7", 16'h0003, 1'b0, 1'b0);
    push("rep_e8", 16'h0004, 1'b0, 1'b0);
    push("rep_e9", 16'h0004, 1'b0, 1'b0);
    push("rep_e10", 16'h0005, 1'b0, 1'b0);
    push("rep_e11", 16'h0005, 1'b0, 1'b0);
    repeat (12) begin cyc(1); drain(); end
    plus = 1'b0;
    cyc(1);
    expect_now("rep_release", 16'h0005, 1'b0, 1'b0);

    // Pause, resume from frozen prescaler, then abort
    pulse_start();
    expect_now("pr_start", 16'h0005, 1'b1, 1'b0);
    push("pr_e1", 16'h0005, 1'b1, 1'b0);
    push("pr_e2", 16'h0004, 1'b1, 1'b0);
    repeat (2) begin cyc(1); drain(); end
    pulse_start();
    expect_now("pause", 16'h0004, 1'b0, 1'b0);
    repeat (10) push("paused", 16'h0004, 1'b0, 1'b0);
    repeat (10) begin cyc(1); drain(); end
    pulse_start();
    expect_now("resume", 16'h0004, 1'b1, 1'b0);
    cyc(1);
    expect_now("resume_tick", 16'h0003, 1'b1, 1'b0);
    do_clear();
    expect_now("abort", 16'h0005, 1'b0, 1'b0);
    repeat (3) push("abort_hold", 16'h0005, 1'b0, 1'b0);
    repeat (3) begin cyc(1); drain(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
